// File: rtl/mor1kx_spr_access_pkg.sv
// SPR address layout shared by the SPR access controller and its config mux:
// group/index field ranges and the group-0 configuration register indices.
package mor1kx_spr_access_pkg;

   localparam int SPR_GROUP_MSB = 15;
   localparam int SPR_GROUP_LSB = 11;
   localparam int SPR_INDEX_MSB = 10;
   localparam int SPR_INDEX_LSB = 0;

   localparam logic [4:0]  SPR_GROUP_SYS      = 5'd0;

   localparam logic [10:0] SPR_VR_INDEX       = 11'd0;
   localparam logic [10:0] SPR_UPR_INDEX      = 11'd1;
   localparam logic [10:0] SPR_CPUCFGR_INDEX  = 11'd2;
   localparam logic [10:0] SPR_DMMUCFGR_INDEX = 11'd3;
   localparam logic [10:0] SPR_IMMUCFGR_INDEX = 11'd4;
   localparam logic [10:0] SPR_DCCFGR_INDEX   = 11'd5;
   localparam logic [10:0] SPR_ICCFGR_INDEX   = 11'd6;
   localparam logic [10:0] SPR_DCFGR_INDEX    = 11'd7;
   localparam logic [10:0] SPR_PCCFGR_INDEX   = 11'd8;
   localparam logic [10:0] SPR_VR2_INDEX      = 11'd9;
   localparam logic [10:0] SPR_AVR_INDEX      = 11'd10;

   function automatic logic [4:0] spr_group(input logic [15:0] addr);
      return addr[SPR_GROUP_MSB:SPR_GROUP_LSB];
   endfunction

   function automatic logic [10:0] spr_index(input logic [15:0] addr);
      return addr[SPR_INDEX_MSB:SPR_INDEX_LSB];
   endfunction

endpackage

// File: rtl/mor1kx_spr_cfg_mux.sv
// Combinational read mux for the group-0 configuration SPRs; hit_o marks
// addresses that are answered locally rather than over the SPR bus.
module mor1kx_spr_cfg_mux
   import mor1kx_spr_access_pkg::*;
(
   input  logic [15:0] addr_i,
   input  logic [31:0] spr_vr,
   input  logic [31:0] spr_vr2,
   input  logic [31:0] spr_upr,
   input  logic [31:0] spr_cpucfgr,
   input  logic [31:0] spr_dmmucfgr,
   input  logic [31:0] spr_immucfgr,
   input  logic [31:0] spr_dccfgr,
   input  logic [31:0] spr_iccfgr,
   input  logic [31:0] spr_dcfgr,
   input  logic [31:0] spr_pccfgr,
   input  logic [31:0] spr_avr,
   output logic [31:0] dat_o,
   output logic        hit_o
);

   // Index decode; anything outside group 0 / index 0..10 is a miss.
   always_comb begin
      dat_o = 32'd0;
      hit_o = 1'b0;
      if (spr_group(addr_i) == SPR_GROUP_SYS) begin
         hit_o = 1'b1;
         case (spr_index(addr_i))
            SPR_VR_INDEX:       dat_o = spr_vr;
            SPR_UPR_INDEX:      dat_o = spr_upr;
            SPR_CPUCFGR_INDEX:  dat_o = spr_cpucfgr;
            SPR_DMMUCFGR_INDEX: dat_o = spr_dmmucfgr;
            SPR_IMMUCFGR_INDEX: dat_o = spr_immucfgr;
            SPR_DCCFGR_INDEX:   dat_o = spr_dccfgr;
            SPR_ICCFGR_INDEX:   dat_o = spr_iccfgr;
            SPR_DCFGR_INDEX:    dat_o = spr_dcfgr;
            SPR_PCCFGR_INDEX:   dat_o = spr_pccfgr;
            SPR_VR2_INDEX:      dat_o = spr_vr2;
            SPR_AVR_INDEX:      dat_o = spr_avr;
            default: begin
               dat_o = 32'd0;
               hit_o = 1'b0;
            end
         endcase
      end else begin
         hit_o = 1'b0;
      end
   end

endmodule

// File: rtl/mor1kx_spr_access.sv
// SPR access controller: answers config reads locally, forwards everything
// else to the SPR bus with a strobe/ack handshake guarded by a timeout.
module mor1kx_spr_access
   import mor1kx_spr_access_pkg::*;
#(
   parameter int OPTION_SPR_TIMEOUT_WIDTH = 8
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [15:0] addr_i,
   input  logic [31:0] wdat_i,
   input  logic        supv_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdat_o,
   output logic        err_o,
   input  logic [31:0] spr_vr,
   input  logic [31:0] spr_vr2,
   input  logic [31:0] spr_upr,
   input  logic [31:0] spr_cpucfgr,
   input  logic [31:0] spr_dmmucfgr,
   input  logic [31:0] spr_immucfgr,
   input  logic [31:0] spr_dccfgr,
   input  logic [31:0] spr_iccfgr,
   input  logic [31:0] spr_dcfgr,
   input  logic [31:0] spr_pccfgr,
   input  logic [31:0] spr_avr,
   output logic [15:0] spr_bus_addr_o,
   output logic        spr_bus_we_o,
   output logic        spr_bus_stb_o,
   output logic [31:0] spr_bus_dat_o,
   input  logic [31:0] spr_bus_dat_i,
   input  logic        spr_bus_ack_i
);

   localparam int W = OPTION_SPR_TIMEOUT_WIDTH;
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [15:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [31:0]   wdat_q, wdat_d;
   logic [31:0]   rdat_q, rdat_d;
   logic          err_q, err_d;
   logic          done_q, busy_q, stb_q, bus_we_q;
   logic [31:0]   cfg_dat_s;
   logic          cfg_hit_s;

   mor1kx_spr_cfg_mux u_cfg_mux (
      .addr_i       (addr_i),
      .spr_vr       (spr_vr),
      .spr_vr2      (spr_vr2),
      .spr_upr      (spr_upr),
      .spr_cpucfgr  (spr_cpucfgr),
      .spr_dmmucfgr (spr_dmmucfgr),
      .spr_immucfgr (spr_immucfgr),
      .spr_dccfgr   (spr_dccfgr),
      .spr_iccfgr   (spr_iccfgr),
      .spr_dcfgr    (spr_dcfgr),
      .spr_pccfgr   (spr_pccfgr),
      .spr_avr      (spr_avr),
      .dat_o        (cfg_dat_s),
      .hit_o        (cfg_hit_s)
   );

   // Next-state, latched request and result computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               addr_d = addr_i;
               we_d   = we_i;
               wdat_d = wdat_i;
               err_d  = 1'b0;
               if (!supv_i) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdat_d  = 32'd0;
               end else if (cfg_hit_s) begin
                  state_d = DONE;
                  if (!we_i) begin
                     rdat_d = cfg_dat_s;
                  end else begin
                     rdat_d = rdat_q;
                  end
               end else begin
                  state_d = BUS;
                  cnt_d   = {W{1'b0}};
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUS: begin
            cnt_d = cnt_q + CNT_ONE;
            // Ack takes priority over a timeout landing in the same cycle.
            if (spr_bus_ack_i) begin
               state_d = DONE;
               err_d   = 1'b0;
               if (!we_q) begin
                  rdat_d = spr_bus_dat_i;
               end else begin
                  rdat_d = rdat_q;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdat_d  = 32'd0;
            end else begin
               state_d = BUS;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= {W{1'b0}};
         addr_q   <= 16'd0;
         we_q     <= 1'b0;
         wdat_q   <= 32'd0;
         rdat_q   <= 32'd0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         stb_q    <= 1'b0;
         bus_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdat_q   <= wdat_d;
         rdat_q   <= rdat_d;
         err_q    <= err_d;
         done_q   <= (state_d == DONE);
         busy_q   <= (state_d != IDLE);
         stb_q    <= (state_d == BUS);
         bus_we_q <= (state_d == BUS) && we_d;
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign rdat_o         = rdat_q;
   assign err_o          = err_q;
   assign spr_bus_addr_o = addr_q;
   assign spr_bus_we_o   = bus_we_q;
   assign spr_bus_stb_o  = stb_q;
   assign spr_bus_dat_o  = wdat_q;

endmodule

// File: doc/mor1kx_spr_access.md
Name: mor1kx_spr_access

Overview:
Sequential SPR access controller. It sits downstream of the configuration-register block and consumes its read-only values.
- Serves l.mfspr/l.mtspr requests from the control stage.
- Reads of group-0 configuration SPRs are answered locally from the cfgrs outputs.
- All other addresses are forwarded to the SPR bus with a strobe/ack handshake, guarded by a timeout counter.
- Returns read data, a one-cycle done pulse and an error flag to the control stage.

Parameters:
OPTION_SPR_TIMEOUT_WIDTH, 8, width of bus-wait counter; timeout after 2**W strobe cycles without ack.

Ports:
clk  input  1  core clock
rst  input  1  reset (see Behaviour)
req_i  input  1  access request; sampled only in IDLE
we_i  input  1  1 = mtspr (write), 0 = mfspr (read)
addr_i  input  16  SPR address; group = [15:11], index = [10:0]
wdat_i  input  32  write data
supv_i  input  1  current supervisor mode (SR[SM])
busy_o  output  1  access in progress; high from cycle after accepted req until done cycle inclusive
done_o  output  1  one-cycle completion pulse
rdat_o  output  32  read data; valid with done_o, held until next done
err_o  output  1  error qualifier, valid with done_o (privilege violation or bus timeout)
spr_vr, spr_vr2, spr_upr, spr_cpucfgr, spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr, spr_dcfgr, spr_pccfgr, spr_avr  input  32 each  configuration register values
spr_bus_addr_o  output  16  bus address
spr_bus_we_o  output  1  bus write enable
spr_bus_stb_o  output  1  bus strobe
spr_bus_dat_o  output  32  bus write data
spr_bus_dat_i  input  32  bus read data, valid with ack
spr_bus_ack_i  input  1  bus acknowledge

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous, active-high.
- Reset values: every output = 0; state = IDLE; counter = 0.

States: IDLE, BUS, DONE.

IDLE:
- On req_i, latch addr/we/wdat. Then evaluate in this order:
  - supv_i=0: go to DONE with err=1, rdat=0. The bus is not touched.
  - Config address (group 0, index 0..10) and read: go to DONE with rdat = the selected register. Index map: 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR.
  - Config address and write: go to DONE with err=0. The write is silently dropped and rdat_o is unchanged.
  - Any other address, including group-0 index >= 11: go to BUS and clear the counter.
- Local access latency: req at cycle N gives done_o at N+1.

BUS:
- spr_bus_stb_o=1 for the whole state; addr/we/dat are held stable from the latched values.
- Counter increments each cycle.
- ack_i in cycle M: capture dat_i into rdat_o (reads only; writes leave rdat_o), err=0, done_o at M+1. stb drops at M+1.
- No ack after 2**W strobe cycles: go to DONE with err=1, rdat=0.
- If ack_i arrives in the same cycle the counter saturates, ack wins.

DONE:
- done_o=1 for exactly one cycle, then return to IDLE.
- A new req_i is accepted only in the cycle after DONE.

Boundary and error cases:
- req_i while busy is ignored. The control stage must hold req_i until done_o.
- ack_i outside BUS is ignored.
- err_o and rdat_o are only meaningful with done_o. err_o is cleared on the next accepted request.
- rst asserted in any state: the next edge returns to IDLE with all outputs 0. No done_o is produced for the aborted access.

Decomposition:
- SPR group/index address constants and field ranges go in the shared defines (mor1kx-defines.v). Add the config-index constants 0..10 there if they are missing.
- The state encoding is local to this block.
- The config read mux is a natural small sub-module, mor1kx_spr_cfg_mux: combinational index -> 32-bit data plus a hit flag.
- The counter and FSM stay in mor1kx_spr_access.

Test Plan:
1. Read addr 0x0002, supv=1, spr_cpucfgr=0x00000620 -> done_o at N+1, rdat_o=0x00000620, err_o=0, spr_bus_stb_o never high.
2. Write addr 0x0001, wdat=0xFFFFFFFF -> done_o at N+1, err_o=0, rdat_o unchanged, no bus strobe.
3. Read addr 0x2800, bus acks after 3 cycles with dat_i=0xDEADBEEF -> stb high 3 cycles, done_o one cycle later, rdat_o=0xDEADBEEF, err_o=0.
4. Timeout with W=4: read addr 0x4000, ack never asserted -> stb high exactly 16 cycles, then done_o with err_o=1, rdat_o=0. A late ack in IDLE has no effect.
5. Read addr 0x000A with supv=0 -> done_o at N+1, err_o=1, rdat_o=0, no strobe.
6. rst asserted in the 2nd BUS cycle, then ack -> stb=0 and busy=0 after the edge, no done_o; the next req to 0x0009 returns spr_vr2 normally.
